adc_capture_seq: RTL
====================

Name: adc_capture_seq

Overview:
- Sequences ADC sample capture into the AXI-Stream S2MM input of the scatter-gather DMA.
- Waits for a sample-aligned sync (optional), frames samples into fixed-length packets with TLAST, and stops after N packets or continues indefinitely.
- Buffers samples against DMA backpressure and counts dropped samples.
- Sits between the deserialised ADC sample stream (already in the clk domain) and the DMA; configured from the peripheral register block.

Parameters:
- DATA_W, 64, sample word width (8 channels x 8 bit, or packed lanes).
- LEN_W, 16, width of the packet-length and packet-count fields.
- FIFO_AW, 4, log2 of buffer depth (16 words).
- CNT_W, 32, width of the status counters.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  asynchronous, active-low reset.
- cfg_enable  in  1  capture enable (level).
- cfg_soft_reset  in  1  synchronous flush/clear, priority over everything except resetn.
- cfg_sync_arm  in  1  1 = wait for in_sync before the first packet.
- cfg_pkt_len  in  LEN_W  words per packet; 0 treated as 1.
- cfg_pkt_count  in  LEN_W  packets per run; 0 = continuous.
- in_valid  in  1  sample strobe (no backpressure on input).
- in_data  in  DATA_W  sample word.
- in_sync  in  1  sync flag, qualified by in_valid.
- m_axis_tdata  out  DATA_W  stream data to DMA.
- m_axis_tvalid  out  1  stream valid.
- m_axis_tready  in  1  stream ready.
- m_axis_tlast  out  1  last word of packet.
- sts_busy  out  1  state not IDLE/DONE.
- sts_done  out  1  state DONE.
- sts_overflow_cnt  out  CNT_W  dropped samples, saturating.
- sts_pkt_cnt  out  CNT_W  packets fully handed to DMA (TLAST handshakes).

Behaviour:
- Reset (resetn low, or cfg_soft_reset high on a clk edge):
  - state IDLE, FIFO empty.
  - All outputs 0, both counters 0.
  - Word and packet counters cleared.
- cfg_pkt_len and cfg_pkt_count are latched on leaving IDLE and held constant for the run.
- FSM transitions:
  - IDLE -> ARM when cfg_enable=1 and cfg_sync_arm=1.
  - IDLE -> RUN when cfg_enable=1 and cfg_sync_arm=0.
  - ARM -> RUN on the first beat with in_valid&in_sync. That sample is written as word 0.
  - ARM -> IDLE if cfg_enable drops.
  - RUN: each in_valid sample is written to the FIFO when not full. The write-side word counter increments and the tlast bit (stored in the FIFO, DATA_W+1 wide) is set at word == len-1. At that word the counter wraps to 0 and the written-packet count increments.
  - RUN -> DRAIN at a packet boundary when written packets == latched count (count != 0), or when cfg_enable=0.
  - cfg_enable falling mid-packet: capture continues until the current packet completes, then RUN -> DRAIN. Packets are never truncated.
  - cfg_enable falling exactly on the boundary write: go straight to DRAIN.
  - DRAIN -> DONE when the FIFO is empty and no beat is pending.
  - DONE -> IDLE when cfg_enable=0.
- Overflow: in_valid with the FIFO full in RUN drops the sample.
  - sts_overflow_cnt increments, saturating at all-ones.
  - The word counter does not advance, so packet length is preserved.
  - Samples in IDLE/ARM/DRAIN/DONE are ignored and not counted.
- Simultaneous FIFO write and read when full: the read frees a slot, but the write is still dropped. Full is evaluated on registered state.
- Output is driven from the FIFO head (first-word fall-through).
  - AXI-S rules: tvalid is never deasserted without a handshake, and tdata/tlast are stable while tvalid&!tready.
  - Latency from the first accepted sample to tvalid: 1 clk.
- sts_pkt_cnt increments on tvalid&tready&tlast.
- in_sync after the run has started is ignored (no resync).

Optional Feature:
- Macro ADC_CAPTURE_TESTPAT_EN.
- When defined:
  - Adds input cfg_testpat (1 bit).
  - When cfg_testpat=1, each written word is replaced by {4{ramp[15:0]}}.
  - ramp is 0 at the start of each run and increments per written word. Dropped samples do not increment it.
  - Timing and framing are unchanged.
- When undefined: the port and the logic are absent, and data always comes from in_data.

Decomposition:
- Package adc_capture_pkg:
  - state enum (IDLE, ARM, RUN, DRAIN, DONE).
  - default widths DATA_W/LEN_W/CNT_W.
  - TESTPAT_LANES=4 constant.
- One sub-module, adc_capture_fifo:
  - synchronous FWFT FIFO, parameters WIDTH and AW.
  - ports: wr_en, wr_data, full, rd_en, rd_data, empty, flush.

Test Plan:
- sync_arm=1, len=4, count=2; sync on the 10th sample, tready=1 -> 8 beats starting with the sync sample, tlast on beats 4 and 8, sts_pkt_cnt=2, sts_done=1, overflow=0.
- sync_arm=0, len=16, count=0, tready=0 for 40 continuous samples, then tready=1 -> 16 words delivered, overflow_cnt=24, packets remain 16 words long.
- Continuous mode, len=8; drop cfg_enable after word 3 of packet 2 -> packet 2 completes (8 words, tlast), DRAIN, DONE; sts_pkt_cnt=2.
- Random tready 50% for 1000 samples, len=100, count=3 -> 300 in-order beats, tdata/tlast stable while stalled, tlast every 100th beat.
- Assert cfg_soft_reset mid-RUN with FIFO non-empty -> next clk: tvalid=0, counters 0, IDLE; a new run restarts with word 0.
- With ADC_CAPTURE_TESTPAT_EN, testpat=1, len=4, count=1 -> tdata = 0x0000..., 0x0001000100010001, ... up to 0x0003000300030003.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and default widths for the ADC capture sequencer.
// Latency/backpressure: not applicable (declarations only).
package adc_capture_pkg;

  localparam int DATA_W        = 64;
  localparam int LEN_W         = 16;
  localparam int CNT_W         = 32;
  localparam int FIFO_AW       = 4;
  localparam int TESTPAT_LANES = 4;
  localparam int RAMP_W        = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RUN,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/adc_capture_fifo.sv
// First-word-fall-through FIFO: written word appears on rd_data 1 clk later.
// Writes while full are ignored; full/empty come from registered pointers only.
module adc_capture_fifo #(
  parameter int WIDTH = 65,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             do_wr, do_rd;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/adc_capture_seq.sv
// Frames ADC samples into fixed-length AXI-S packets for the DMA; tvalid 1 clk after first write.
// Input cannot stall: samples arriving with the buffer full are dropped and counted.
// Optional ramp test pattern on the written data via ADC_CAPTURE_TESTPAT_EN.
module adc_capture_seq #(
  parameter int DATA_W  = adc_capture_pkg::DATA_W,
  parameter int LEN_W   = adc_capture_pkg::LEN_W,
  parameter int FIFO_AW = adc_capture_pkg::FIFO_AW,
  parameter int CNT_W   = adc_capture_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cfg_enable,
  input  logic              cfg_soft_reset,
  input  logic              cfg_sync_arm,
  input  logic [LEN_W-1:0]  cfg_pkt_len,
  input  logic [LEN_W-1:0]  cfg_pkt_count,
`ifdef ADC_CAPTURE_TESTPAT_EN
  input  logic              cfg_testpat,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sync,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              sts_busy,
  output logic              sts_done,
  output logic [CNT_W-1:0]  sts_overflow_cnt,
  output logic [CNT_W-1:0]  sts_pkt_cnt
);
  import adc_capture_pkg::*;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, cnt_q, word_q, word_d, pkts_q, pkts_d;
  logic [CNT_W-1:0]  ovf_q, ovf_d, pkt_cnt_q;
  logic              busy_q, done_q;
  logic              fifo_full, fifo_empty, accept, wr_en, drop;
  logic              last_word, boundary_stop, rd_fire;
  logic [DATA_W-1:0] wr_dat;
  logic [DATA_W:0]   fifo_rd;

`ifdef ADC_CAPTURE_TESTPAT_EN
  logic [RAMP_W-1:0] ramp_q;
  assign wr_dat = cfg_testpat ? DATA_W'({TESTPAT_LANES{ramp_q}}) : in_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                ramp_q <= '0;
    else if (cfg_soft_reset)    ramp_q <= '0;
    else if (state_q == IDLE)   ramp_q <= '0;
    else if (wr_en)             ramp_q <= ramp_q + 1'b1;
  end
`else
  assign wr_dat = in_data;
`endif

  // A zero length behaves as one word per packet.
  assign last_word = (len_q == '0) ? (word_q == '0) : (word_q == len_q - 1'b1);

  always_comb begin
    // Once enable drops, only the rest of an already started packet is accepted.
    accept  = in_valid && (((state_q == ARM) && cfg_enable && in_sync) ||
                           ((state_q == RUN) && (cfg_enable || (word_q != '0))));
    wr_en   = accept && !fifo_full;
    drop    = accept && fifo_full;
    word_d  = word_q;
    pkts_d  = pkts_q;
    if (wr_en) begin
      if (last_word) begin
        word_d = '0;
        pkts_d = pkts_q + 1'b1;
      end else begin
        word_d = word_q + 1'b1;
      end
    end
    boundary_stop = wr_en && last_word &&
                    (((cnt_q != '0) && (pkts_d == cnt_q)) || !cfg_enable);
    ovf_d   = (drop && !(&ovf_q)) ? ovf_q + 1'b1 : ovf_q;
    state_d = state_q;
    case (state_q)
      IDLE:    if (cfg_enable) state_d = cfg_sync_arm ? ARM : RUN;
      ARM: begin
        if (!cfg_enable)        state_d = IDLE;
        else if (boundary_stop) state_d = DRAIN;
        else if (wr_en)         state_d = RUN;
      end
      RUN:     if (boundary_stop || (!cfg_enable && (word_q == '0))) state_d = DRAIN;
      DRAIN:   if (fifo_empty) state_d = DONE;
      DONE:    if (!cfg_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      pkts_q    <= '0;
      ovf_q     <= '0;
      pkt_cnt_q <= '0;
    end else if (cfg_soft_reset) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      word_q    <= '0;
      pkts_q    <= '0;
      ovf_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ARM) || (state_d == RUN) || (state_d == DRAIN);
      done_q  <= (state_d == DONE);
      ovf_q   <= ovf_d;
      if (rd_fire && fifo_rd[DATA_W]) pkt_cnt_q <= pkt_cnt_q + 1'b1;
      // Configuration tracks the inputs while idle, so it is frozen on leaving IDLE.
      if (state_q == IDLE) begin
        len_q  <= cfg_pkt_len;
        cnt_q  <= cfg_pkt_count;
        word_q <= '0;
        pkts_q <= '0;
      end else begin
        word_q <= word_d;
        pkts_q <= pkts_d;
      end
    end
  end

  adc_capture_fifo #(
    .WIDTH (DATA_W + 1),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .flush   (cfg_soft_reset),
    .wr_en   (wr_en),
    .wr_data ({last_word, wr_dat}),
    .full    (fifo_full),
    .rd_en   (rd_fire),
    .rd_data (fifo_rd),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid    = !fifo_empty;
  assign rd_fire          = m_axis_tvalid && m_axis_tready;
  assign m_axis_tdata     = fifo_rd[DATA_W-1:0] & {DATA_W{m_axis_tvalid}};
  assign m_axis_tlast     = fifo_rd[DATA_W] & m_axis_tvalid;
  assign sts_busy         = busy_q;
  assign sts_done         = done_q;
  assign sts_overflow_cnt = ovf_q;
  assign sts_pkt_cnt      = pkt_cnt_q;

endmodule
